video2axis: RTL and testbench
=============================

VIDEO2AXIS -- requirements
Module: video2axis

Interface
REQ-001 Parameter DATA_WIDTH, default 16: pixel width in bits.
REQ-002 Parameter FIFO_DEEP, default 1024: output FIFO depth in words (power of 2).
REQ-003 s_axis_aclk  input  1  sole clock; all ports are synchronous to it.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 ACTIVE_WIDTH  input  16  pixels per line; quasi-static, sampled only in ST_IDLE.
REQ-006 ACTIVE_HEIGHT  input  16  lines per frame; quasi-static, sampled only in ST_IDLE.
REQ-007 din  input  DATA_WIDTH  video pixel data.
REQ-008 en_in  input  1  pixel valid; no backpressure on the video side.
REQ-009 vs_in  input  1  frame-active level; a rising edge starts a frame.
REQ-010 m_axis_tdata  output  DATA_WIDTH  stream pixel.
REQ-011 m_axis_tuser  output  1  start of frame, on the first pixel only.
REQ-012 m_axis_tlast  output  1  end of line, on pixel ACTIVE_WIDTH-1 of each line.
REQ-013 m_axis_tvalid  output  1 / m_axis_tready  input  1  AXI4-Stream handshake.
REQ-014 overflow  output  1  one-cycle pulse when a pixel is lost because the FIFO is full.
REQ-015 line_err, frame_err  output  1 each  one-cycle framing-error pulses (see REQ-033).

Function
REQ-016 States: ST_IDLE, ST_ACTIVE and ST_DROP; the state register, xcnt and ycnt are 16 bits each.
REQ-017 ST_IDLE->ST_ACTIVE on the vs_in rising edge (vs_in=1 and previous vs_in=0); this transition latches ACTIVE_WIDTH/HEIGHT and sets xcnt=ycnt=0.
REQ-018 A pixel is written when state==ST_ACTIVE, en_in=1 and the FIFO is not full; a pixel with en_in on the edge cycle itself is also accepted as pixel (0,0).
REQ-019 FIFO word = {tlast, tuser, din}; tuser=(xcnt==0 && ycnt==0); tlast=(xcnt==ACTIVE_WIDTH-1).
REQ-020 On each write, xcnt increments; at ACTIVE_WIDTH-1, xcnt wraps to 0 and ycnt increments.
REQ-021 A write with xcnt==ACTIVE_WIDTH-1 and ycnt==ACTIVE_HEIGHT-1 moves the FSM to ST_IDLE; further en_in in the frame is ignored.
REQ-022 vs_in falling while in ST_ACTIVE moves the FSM to ST_IDLE; a partial frame is not padded.
REQ-023 en_in=1 with the FIFO full in ST_ACTIVE: the pixel is discarded, overflow pulses, and the FSM enters ST_DROP.
REQ-024 ST_DROP discards all input and returns to ST_IDLE only on vs_in=0.
REQ-025 ACTIVE_WIDTH==0 or ACTIVE_HEIGHT==0: the FSM stays in ST_IDLE and writes nothing.
REQ-026 The FIFO is synchronous and first-word-fall-through; m_axis_tvalid=!empty.
REQ-027 A pop occurs on m_axis_tvalid && m_axis_tready; the m_axis_* fields come directly from the FIFO head.
REQ-028 Latency: a pixel written at cycle N into an empty FIFO is presented at N+1.
REQ-029 With tvalid=1, tdata/tuser/tlast hold stable until the pop.
REQ-030 A simultaneous write and pop at full is allowed only via the write-blocked path: full is evaluated before the pop, so the pixel is dropped.

Reset
REQ-031 Reset values: state=ST_IDLE; xcnt=ycnt=0; FIFO empty; m_axis_tvalid=0; overflow=line_err=frame_err=0.
REQ-032 Reset asserted mid-frame flushes the FIFO; after release, the block waits for a fresh vs_in rising edge, so vs_in already high does not start a frame.

Configuration
REQ-033 Macro VIDEO2AXIS_FRAME_CHECK_EN defined:
- line_err pulses when en_in falls in ST_ACTIVE with xcnt!=0 (short line).
- line_err also pulses when en_in=1 in ST_ACTIVE after tlast without an en_in gap (long line).
- frame_err pulses when vs_in falls in ST_ACTIVE (short frame).
REQ-034 Macro undefined: line_err and frame_err are tied to 0, and no check logic is built.

Verification
REQ-035 W=4, H=2, one frame of 8 pixels 0..7, tready=1 -> 8 beats; tuser only on data 0; tlast on data 3 and 7; FSM returns to ST_IDLE.
REQ-036 Same frame with tready=0 for 20 cycles, then 1 -> no loss; the beats hold stable, then drain in order.
REQ-037 FIFO_DEEP=4, W=8, H=1, tready=0 -> overflow pulses once on pixel 4; remaining pixels are dropped; next frame (vs_in toggles) is streamed intact after draining.
REQ-038 W=4, H=2, vs_in falls after 5 pixels -> 5 beats with tlast on beat 3; with the macro, frame_err=1 for one cycle.
REQ-039 rst_n=0 during pixel 2 with vs_in held high -> FIFO empty, tvalid=0, no output until the next vs_in rise.
REQ-040 Macro defined, W=4, a line with 3 pixels then an en_in gap -> line_err pulses once.

Source files
------------

// File: rtl/video2axis.sv
// video2axis: parallel video (vs/en/data) to AXI4-Stream through a FWFT FIFO.
// Optional framing checks are built when VIDEO2AXIS_FRAME_CHECK_EN is defined.
module video2axis #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEEP  = 1024
) (
  input  logic                  s_axis_aclk,
  input  logic                  rst_n,
  input  logic [15:0]           ACTIVE_WIDTH,
  input  logic [15:0]           ACTIVE_HEIGHT,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  en_in,
  input  logic                  vs_in,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overflow,
  output logic                  line_err,
  output logic                  frame_err
);

  localparam int AW = $clog2(FIFO_DEEP);
  localparam int FW = DATA_WIDTH + 2;

  typedef enum logic [15:0] {
    ST_IDLE   = 16'd0,
    ST_ACTIVE = 16'd1,
    ST_DROP   = 16'd2
  } state_t;

  state_t        state, state_nx;
  logic [15:0]   xcnt, ycnt, xcnt_nx, ycnt_nx;
  logic [15:0]   wid, hgt, wid_nx, hgt_nx;
  logic [15:0]   cx, cy, cw, ch;
  logic          vs_d;
  logic          start, take, wr, rd, ovf_nx;
  logic          full, empty;
  logic [FW-1:0] wdata;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [FW-1:0] mem [FIFO_DEEP];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd    = !empty && m_axis_tready;

  assign start = (state == ST_IDLE) && vs_in && !vs_d &&
                 (ACTIVE_WIDTH != 16'd0) && (ACTIVE_HEIGHT != 16'd0);

  // Next-state, counter advance and FIFO write decision
  always_comb begin
    state_nx = state;
    xcnt_nx  = xcnt;
    ycnt_nx  = ycnt;
    wid_nx   = wid;
    hgt_nx   = hgt;
    cx       = xcnt;
    cy       = ycnt;
    cw       = wid;
    ch       = hgt;
    take     = 1'b0;
    wr       = 1'b0;
    ovf_nx   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_ACTIVE;
          wid_nx   = ACTIVE_WIDTH;
          hgt_nx   = ACTIVE_HEIGHT;
          xcnt_nx  = 16'd0;
          ycnt_nx  = 16'd0;
          cx       = 16'd0;
          cy       = 16'd0;
          cw       = ACTIVE_WIDTH;
          ch       = ACTIVE_HEIGHT;
          take     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        take = 1'b1;
        if (!vs_in) state_nx = ST_IDLE;
      end
      ST_DROP: begin
        if (!vs_in) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (take && en_in) begin
      if (full) begin
        ovf_nx   = 1'b1;
        state_nx = ST_DROP;
      end else begin
        wr = 1'b1;
        if (cx == cw - 16'd1) begin
          xcnt_nx = 16'd0;
          ycnt_nx = cy + 16'd1;
          if (cy == ch - 16'd1) state_nx = ST_IDLE;
        end else begin
          xcnt_nx = cx + 16'd1;
        end
      end
    end
    wdata = {(cx == cw - 16'd1), (cx == 16'd0 && cy == 16'd0), din};
  end

  // Control registers; vs_d resets high so a level already high is no edge
  always_ff @(posedge s_axis_aclk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      xcnt     <= 16'd0;
      ycnt     <= 16'd0;
      wid      <= 16'd0;
      hgt      <= 16'd0;
      vs_d     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      xcnt     <= xcnt_nx;
      ycnt     <= ycnt_nx;
      wid      <= wid_nx;
      hgt      <= hgt_nx;
      vs_d     <= vs_in;
      overflow <= ovf_nx;
    end
  end

  // FIFO pointers; full is judged before the pop
  always_ff @(posedge s_axis_aclk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge s_axis_aclk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = mem[rd_ptr[AW-1:0]];
  assign m_axis_tvalid = !empty;

`ifdef VIDEO2AXIS_FRAME_CHECK_EN
  logic en_d, last_d;

  // Short/long line and short frame detection
  always_ff @(posedge s_axis_aclk) begin
    if (!rst_n) begin
      en_d      <= 1'b0;
      last_d    <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      en_d      <= en_in;
      last_d    <= wr && wdata[FW-1];
      line_err  <= (state == ST_ACTIVE) &&
                   ((en_d && !en_in && xcnt != 16'd0) ||
                    (en_in && last_d));
      frame_err <= (state == ST_ACTIVE) && vs_d && !vs_in;
    end
  end
`else
  assign line_err  = 1'b0;
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_video2axis.sv
// tb_video2axis: two DUTs (deep and 4-word FIFO) against a pixel-index model.
// Directed frames plus randomized framing, gaps and backpressure.
module tb_video2axis;

  localparam int DW = 16;
  localparam int D0 = 1024;
  localparam int D1 = 4;
`ifdef VIDEO2AXIS_FRAME_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n = 1'b0;
  logic [15:0]         aw = 16'd4;
  logic [15:0]         ah = 16'd2;
  logic [DW-1:0]       din = '0;
  logic                en = 1'b0;
  logic                vs = 1'b0;
  logic [1:0]          rdy = 2'b11;
  logic [1:0][DW-1:0]  td;
  logic [1:0]          tu, tl, tv, ov, le, fe;

  video2axis #(.DATA_WIDTH(DW), .FIFO_DEEP(D0)) u_dut (
    .s_axis_aclk(clk), .rst_n(rst_n),
    .ACTIVE_WIDTH(aw), .ACTIVE_HEIGHT(ah),
    .din(din), .en_in(en), .vs_in(vs),
    .m_axis_tdata(td[0]), .m_axis_tuser(tu[0]),
    .m_axis_tlast(tl[0]), .m_axis_tvalid(tv[0]),
    .m_axis_tready(rdy[0]), .overflow(ov[0]),
    .line_err(le[0]), .frame_err(fe[0])
  );

  video2axis #(.DATA_WIDTH(DW), .FIFO_DEEP(D1)) u_small (
    .s_axis_aclk(clk), .rst_n(rst_n),
    .ACTIVE_WIDTH(aw), .ACTIVE_HEIGHT(ah),
    .din(din), .en_in(en), .vs_in(vs),
    .m_axis_tdata(td[1]), .m_axis_tuser(tu[1]),
    .m_axis_tlast(tl[1]), .m_axis_tvalid(tv[1]),
    .m_axis_tready(rdy[1]), .overflow(ov[1]),
    .line_err(le[1]), .frame_err(fe[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Model: a frame is a run of pixel indices; FIFO is a ring of words
  int            depth [2] = '{D0, D1};
  logic [DW+1:0] mq [2][D0];
  int            mhead [2] = '{0, 0};
  int            mcnt [2] = '{0, 0};
  bit            infr [2] = '{0, 0};
  bit            drp [2] = '{0, 0};
  int            pidx [2] = '{0, 0};
  int            fw [2] = '{1, 1};
  int            fh [2] = '{1, 1};
  bit            e_ovf [2] = '{0, 0};
  bit            e_le [2] = '{0, 0};
  bit            e_fe [2] = '{0, 0};
  bit            wlast [2] = '{0, 0};
  bit            pvs = 1'b1;
  bit            pen = 1'b0;
  bit            chk = 1'b0;

  task automatic mstep(input int i);
    bit            pop, wr, take, tlb, tub;
    int            x;
    logic [DW+1:0] w;
    w = '0;
    if (!rst_n) begin
      mcnt[i] = 0; mhead[i] = 0;
      infr[i] = 0; drp[i] = 0;
      e_ovf[i] = 0; e_le[i] = 0; e_fe[i] = 0;
      wlast[i] = 0;
      return;
    end
    pop = (mcnt[i] > 0) && rdy[i];
    x = infr[i] ? (pidx[i] % fw[i]) : 0;
    e_le[i] = 0;
    e_fe[i] = 0;
    if (CHK == 1) begin
      e_fe[i] = infr[i] && pvs && !vs;
      e_le[i] = infr[i] && ((pen && !en && x != 0) ||
                            (en && wlast[i]));
    end
    take = 0; wr = 0; e_ovf[i] = 0;
    if (drp[i]) begin
      if (!vs) drp[i] = 0;
    end else if (infr[i]) begin
      take = 1;
      if (!vs) infr[i] = 0;
    end else if (vs && !pvs && aw != 0 && ah != 0) begin
      take = 1; infr[i] = 1; pidx[i] = 0;
      fw[i] = int'(aw); fh[i] = int'(ah);
    end
    if (take && en) begin
      if (mcnt[i] == depth[i]) begin
        e_ovf[i] = 1; drp[i] = 1; infr[i] = 0;
      end else begin
        wr  = 1;
        tlb = (pidx[i] % fw[i]) == fw[i] - 1;
        tub = (pidx[i] == 0);
        w   = {tlb, tub, din};
        pidx[i]++;
        if (pidx[i] == fw[i] * fh[i]) infr[i] = 0;
      end
    end
    wlast[i] = wr && w[DW+1];
    if (pop) begin
      mhead[i] = (mhead[i] + 1) % depth[i];
      mcnt[i]--;
    end
    if (wr) begin
      mq[i][(mhead[i] + mcnt[i]) % depth[i]] = w;
      mcnt[i]++;
    end
  endtask

  // Advance the model on every active edge
  always @(posedge clk) begin
    mstep(0);
    mstep(1);
    if (!rst_n) begin
      pvs = 1'b1; pen = 1'b0; chk = 1'b1;
    end else begin
      pvs = vs; pen = en;
    end
  end

  // Compare both DUTs with the model every cycle
  always @(negedge clk) begin
    if (chk) begin
      for (int i = 0; i < 2; i++) begin
        cmp($sformatf("tvalid%0d", i), 32'(tv[i]), 32'(mcnt[i] > 0));
        if (mcnt[i] > 0)
          cmp($sformatf("beat%0d", i), 32'({tl[i], tu[i], td[i]}),
              32'(mq[i][mhead[i]]));
        cmp($sformatf("overflow%0d", i), 32'(ov[i]), 32'(e_ovf[i]));
        cmp($sformatf("line_err%0d", i), 32'(le[i]), 32'(e_le[i]));
        cmp($sformatf("frame_err%0d", i), 32'(fe[i]), 32'(e_fe[i]));
      end
    end
  end

  // Beat log and pulse counters for the literal checks
  logic [DW+1:0] log0[$], log1[$];
  int novf1 = 0, nle0 = 0, nfe0 = 0;
  always @(negedge clk) begin
    if (chk) begin
      if (tv[0] && rdy[0]) log0.push_back({tl[0], tu[0], td[0]});
      if (tv[1] && rdy[1]) log1.push_back({tl[1], tu[1], td[1]});
      if (ov[1]) novf1++;
      if (le[0]) nle0++;
      if (fe[0]) nfe0++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input bit e, input int d);
    vs = v; en = e; din = DW'(d);
    tick();
  endtask

  // Rise, npix pixels with a gap after each line end, extra ignored pixels
  task automatic frame(input int w, input int h, input int base,
                       input int npix, input int extra);
    aw = 16'(w); ah = 16'(h);
    drv(1, 0, 0);
    for (int p = 0; p < npix; p++) begin
      drv(1, 1, base + p);
      if ((p % w) == w - 1) drv(1, 0, 0);
    end
    for (int p = 0; p < extra; p++) drv(1, 1, 900 + p);
    drv(0, 0, 0);
    drv(0, 0, 0);
  endtask

  task automatic chk_log0(input string n, input int cnt, input int base,
                          input int w);
    cmp({n, "_n"}, log0.size(), cnt);
    for (int k = 0; k < log0.size(); k++) begin
      cmp({n, "_d"}, 32'(log0[k][DW-1:0]), base + k);
      cmp({n, "_u"}, 32'(log0[k][DW]), 32'(k == 0));
      cmp({n, "_l"}, 32'(log0[k][DW+1]), 32'((k % w) == w - 1));
    end
  endtask

  initial begin
    repeat (3) tick();
    cmp("rst_tvalid", 32'(tv), 0);
    cmp("rst_ovf", 32'(ov), 0);
    cmp("rst_err", 32'({le, fe}), 0);
    rst_n = 1'b1;
    tick();
    cmp("idle_tvalid", 32'(tv), 0);

    // 4x2 frame, full-rate sink; pixels after the frame end are ignored
    log0.delete();
    frame(4, 2, 0, 8, 2);
    repeat (4) tick();
    chk_log0("f35", 8, 0, 4);

    // Same frame held back for ~20 cycles, then drained in order
    log0.delete();
    rdy[0] = 1'b0;
    frame(4, 2, 0, 8, 0);
    repeat (8) tick();
    cmp("hold_valid", 32'(tv[0]), 1);
    cmp("hold_head", 32'({tl[0], tu[0], td[0]}), 32'({2'b01, 16'd0}));
    cmp("hold_nolog", log0.size(), 0);
    rdy[0] = 1'b1;
    repeat (10) tick();
    chk_log0("f36", 8, 0, 4);

    // 4-word FIFO overflow on pixel 4, then an intact next frame
    log1.delete();
    novf1 = 0;
    rdy[1] = 1'b0;
    frame(8, 1, 0, 8, 0);
    repeat (3) tick();
    cmp("ovf_once", novf1, 1);
    rdy[1] = 1'b1;
    repeat (6) tick();
    cmp("ovf_kept", log1.size(), 4);
    for (int k = 0; k < log1.size(); k++)
      cmp("ovf_data", 32'(log1[k][DW-1:0]), k);
    log1.delete();
    frame(8, 1, 16, 8, 0);
    repeat (12) tick();
    cmp("f37b_n", log1.size(), 8);
    for (int k = 0; k < log1.size(); k++)
      cmp("f37b", 32'(log1[k]), 32'({k == 7, k == 0, 16'(16 + k)}));

    // vs falls after 5 pixels: partial frame, not padded
    log0.delete();
    nfe0 = 0;
    frame(4, 2, 40, 5, 0);
    repeat (4) tick();
    chk_log0("f38", 5, 40, 4);
    cmp("f38_ferr", nfe0, CHK);

    // Reset during pixel 2 with vs held high
    rdy = 2'b00;
    aw = 16'd4; ah = 16'd2;
    drv(1, 0, 0);
    drv(1, 1, 50);
    drv(1, 1, 51);
    rst_n = 1'b0;
    drv(1, 1, 52);
    drv(1, 1, 53);
    rst_n = 1'b1;
    cmp("rst_flush", 32'(tv), 0);
    rdy = 2'b11;
    log0.delete();
    for (int p = 0; p < 4; p++) drv(1, 1, 60 + p);
    cmp("no_restart_v", 32'(tv), 0);
    cmp("no_restart_n", log0.size(), 0);
    drv(0, 0, 0);
    frame(4, 2, 70, 8, 0);
    repeat (4) tick();
    chk_log0("f39", 8, 70, 4);

    // Short line: 3 pixels then a gap
    nle0 = 0;
    aw = 16'd4; ah = 16'd2;
    drv(1, 0, 0);
    for (int p = 0; p < 3; p++) drv(1, 1, 80 + p);
    drv(1, 0, 0);
    drv(0, 0, 0);
    drv(0, 0, 0);
    cmp("short_line", nle0, CHK);
    repeat (4) tick();

    // Zero width or height never starts a frame
    log0.delete();
    aw = 16'd0; ah = 16'd2;
    drv(1, 0, 0);
    for (int p = 0; p < 3; p++) drv(1, 1, p);
    drv(0, 0, 0);
    aw = 16'd3; ah = 16'd0;
    drv(1, 1, 5);
    drv(1, 1, 6);
    drv(0, 0, 0);
    repeat (3) tick();
    cmp("zero_dim", log0.size(), 0);

    // Random frames, gaps, early vs fall and backpressure
    for (int f = 0; f < 60; f++) begin
      int w, h, len, cut;
      w = $urandom_range(1, 6);
      h = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
      aw = 16'(w); ah = 16'(h);
      len = $urandom_range(w * h + 1, 2 * w * h + 6);
      cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : len;
      for (int c = 0; c < len; c++) begin
        rdy = 2'($urandom);
        vs = (c < cut);
        en = ($urandom_range(0, 3) != 0);
        din = DW'($urandom);
        tick();
      end
      vs = 1'b0; en = 1'b0;
      rdy = 2'($urandom);
      tick();
      tick();
    end
    rdy = 2'b11;
    repeat (30) tick();
    cmp("end_empty", 32'(tv), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
